gpu_host_bridge: RTL and testbench
==================================

# gpu_host_bridge

Parametrised HPS-to-GPU command bridge. It decodes the 32-bit H2F PIO word into a request/busy handshake and drives a shared RAM/register access bus to any of `CORE_COUNT` shader cores. It also publishes per-core run control, aggregated halted/exception status, and command results on the 32-bit F2H word. It sits between the HPS PIO registers and the array of ShaderCore instances.

## Interface
- `WORD_WIDTH`, 32, data word width
- `ADDRESS_WIDTH`, 16, RAM/register address width; must be ≤ 16
- `CORE_COUNT`, 4, number of cores, 1..16
- `READ_TIMEOUT`, 15, maximum cycles to wait for `read_valid`
- `clock` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high.
- `h2f_value` in 32: `[31]` host reset_n, `[30]` run, `[29]` request, `[23:16]` command, `[15:0]` parameter.
- `f2h_value` out 32: `{exited_reset, busy, cmd_error, any_halted, any_exception, 3'b0, data_field[23:0]}`.
- `core_reset_n` out 1: `!reset && h2f_value[31]`.
- `core_run` out `CORE_COUNT`: `run_mask & {CORE_COUNT{h2f_value[30]}}`.
- `core_halted` in `CORE_COUNT`: per-core halted flag.
- `core_exception` in `CORE_COUNT`: per-core exception flag.
- `core_exception_data` in `24*CORE_COUNT`: per-core exception data; core i occupies `[24i+23:24i]`.
- `core_select` out `CORE_COUNT`: one-hot target, or all ones for broadcast writes.
- `enable_write_inst_ram`, `enable_write_data_ram`, `enable_read_inst_ram`, `enable_read_data_ram`, `enable_read_register`, `enable_read_floatreg`, `enable_read_special` out 1 each: one-cycle strobes.
- `rw_address` out `ADDRESS_WIDTH`: access address.
- `write_data` out `WORD_WIDTH`: the write register.
- `read_data` in `WORD_WIDTH`: read-back data, already muxed from the selected core.
- `read_valid` in 1: `read_data` is valid this cycle.

## Operation
- Commands:
  - 0 PUT_LOW16: `write_reg[15:0] ← param`.
  - 1 PUT_HIGH16: `write_reg[31:16] ← param`.
  - 2 SET_ADDRESS: `addr_reg ← param`.
  - 3 SET_CORE: `param[4]=1` selects broadcast; otherwise core `param[3:0]`. Index ≥ `CORE_COUNT` is an error.
  - 4 WRITE_INST and 5 WRITE_DATA: write `write_reg` at `addr_reg`, then `addr_reg += 1`, wrapping modulo `2^ADDRESS_WIDTH`.
  - 6 READ_INST and 7 READ_DATA: read at `addr_reg` into `read_reg`, then `addr_reg += 1`.
  - 8 READ_X, 9 READ_F, 10 READ_SPECIAL: read at `param[4:0]`; `addr_reg` is unchanged.
  - 11 GET_LOW16 and 12 GET_HIGH16: `data_field ← {8'b0, read_reg half}`.
  - 13 SET_RUN_MASK: `run_mask ← param[CORE_COUNT-1:0]`.
  - 14 GET_EXCEPTION: `data_field ←` exception data of the lowest-index excepting core, or 0 if none.
- Errors set `cmd_error=1` and `data_field=24'hdead00`. Error causes:
  - unknown command;
  - invalid core index;
  - any read issued while broadcast is selected;
  - read timeout (`data_field=24'hdead01`).
- `cmd_error` clears when the next command is accepted.
- Commands are ignored (not accepted) while `h2f_value[30]` (run) is 1.
- FSM states: INIT, IDLE, ISSUE, WAIT_READ, DONE.
  - INIT: `exited_reset ← 1`, go to IDLE.
  - IDLE: on request=1 and run=0, latch command/param, `busy ← 1`, go to ISSUE.
  - ISSUE: pulse the strobe for one cycle, drive `rw_address` and `core_select`. Writes and non-bus commands go to DONE; reads go to WAIT_READ.
  - WAIT_READ: on `read_valid`, `read_reg ← read_data` and go to DONE. After `READ_TIMEOUT` cycles without `read_valid`, raise the error and go to DONE.
  - DONE: wait for request=0, then `busy ← 0`, go to IDLE.
- Host soft reset (`h2f[31]=0`) behaves like `reset` for the bridge state, except that `write_reg` and `read_reg` are preserved.

## Timing
- Reset values:
  - `exited_reset=0`, `busy=1`, `cmd_error=0`, `data_field=0`;
  - `addr_reg=0`, `run_mask` all ones, core select = core 0;
  - all strobes 0, `rw_address=0`;
  - `write_reg` and `read_reg` = 0; state INIT.
- `exited_reset` rises on the first cycle after reset is released.
- `busy` falls one cycle after INIT.
- Request seen in IDLE at cycle n:
  - `busy=1` at n+1;
  - strobe high for exactly cycle n+1 (ISSUE);
  - a write completes with `busy=0` at n+3, if request is already low.
- Reads:
  - `read_valid` may arrive in the same cycle as the strobe or up to `READ_TIMEOUT` cycles later;
  - `read_valid` outside WAIT_READ is ignored.
- Request held high keeps the FSM in DONE. There is no re-trigger; a new command requires a 1→0→1 transition.
- Reset mid-operation:
  - all strobes drop the next cycle;
  - a pending read is abandoned;
  - any late `read_valid` is ignored.
- `any_halted` and `any_exception` are the combinational OR of the core inputs, masked by nothing.

## Structure
- Package `gpu_host_bridge_pkg` holds:
  - command codes;
  - FSM state encoding;
  - F2H bit positions;
  - error constants (`dead00`, `dead01`).
- One sub-module, `gpu_exception_select`: a combinational priority encoder that picks the lowest-index excepting core's data.

## Test plan
- Reset released → cycle +1 `f2h[31]=1`, then `f2h[30]=0`; `core_run=4'b0000` with run=0.
- SET_CORE 2, SET_ADDRESS 0xFFFF, PUT 0xDEADBEEF, WRITE_DATA ×2 → `core_select=4'b0100`, writes at 0xFFFF then 0x0000, `write_data=0xDEADBEEF`.
- READ_INST with `read_valid` 3 cycles after the strobe, `read_data=0x12345678` → GET_LOW16 gives `data_field=0x005678`; GET_HIGH16 gives `0x001234`.
- READ_DATA with no `read_valid` for 15 cycles → `cmd_error=1`, `data_field=0xdead01`, `busy=0` after request drops.
- SET_CORE broadcast then READ_X → error 0xdead00 with no strobe. SET_CORE 9 with CORE_COUNT=4 → error.
- SET_RUN_MASK 0b0101, run=1 → `core_run=4'b0101`. A request during run is ignored (`busy` stays 0). Core 1 exception with data 0xABCDEF, then GET_EXCEPTION after run=0 → `data_field=0xABCDEF`, `f2h[27]=1`.

Source files
------------

// File: rtl/gpu_host_bridge_pkg.sv
// Shared definitions for the HPS-to-GPU command bridge.
// Holds command codes, FSM state encoding, H2F/F2H bit positions, error
// payloads, the bus strobe bundle and a small command classifier.
package gpu_host_bridge_pkg;

    // Host command codes (h2f_value[23:16])
    localparam logic [7:0] CMD_PUT_LOW16      = 8'd0;
    localparam logic [7:0] CMD_PUT_HIGH16     = 8'd1;
    localparam logic [7:0] CMD_SET_ADDRESS    = 8'd2;
    localparam logic [7:0] CMD_SET_CORE       = 8'd3;
    localparam logic [7:0] CMD_WRITE_INST     = 8'd4;
    localparam logic [7:0] CMD_WRITE_DATA     = 8'd5;
    localparam logic [7:0] CMD_READ_INST      = 8'd6;
    localparam logic [7:0] CMD_READ_DATA      = 8'd7;
    localparam logic [7:0] CMD_READ_REGISTER  = 8'd8;
    localparam logic [7:0] CMD_READ_FLOATREG  = 8'd9;
    localparam logic [7:0] CMD_READ_SPECIAL   = 8'd10;
    localparam logic [7:0] CMD_GET_LOW16      = 8'd11;
    localparam logic [7:0] CMD_GET_HIGH16     = 8'd12;
    localparam logic [7:0] CMD_SET_RUN_MASK   = 8'd13;
    localparam logic [7:0] CMD_GET_EXCEPTION  = 8'd14;

    // FSM state encoding
    localparam logic [2:0] ST_INIT      = 3'd0;
    localparam logic [2:0] ST_IDLE      = 3'd1;
    localparam logic [2:0] ST_ISSUE     = 3'd2;
    localparam logic [2:0] ST_WAIT_READ = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    // H2F control bit positions
    localparam int unsigned H2F_RESET_N = 31;
    localparam int unsigned H2F_RUN     = 30;
    localparam int unsigned H2F_REQUEST = 29;

    // F2H status bit positions; bits [26:24] are zero, [23:0] is the data field
    localparam int unsigned F2H_EXITED_RESET  = 31;
    localparam int unsigned F2H_BUSY          = 30;
    localparam int unsigned F2H_CMD_ERROR     = 29;
    localparam int unsigned F2H_ANY_HALTED    = 28;
    localparam int unsigned F2H_ANY_EXCEPTION = 27;
    localparam int unsigned DATA_FIELD_WIDTH  = 24;

    // Error payloads placed in the data field
    localparam logic [23:0] ERR_DEAD00 = 24'hdead00;
    localparam logic [23:0] ERR_DEAD01 = 24'hdead01;

    // One-cycle access strobes toward the core array
    typedef struct packed {
        logic write_inst;
        logic write_data;
        logic read_inst;
        logic read_data;
        logic read_register;
        logic read_floatreg;
        logic read_special;
    } strobe_t;

    // True for every command that issues a bus read
    function automatic logic is_read_cmd(input logic [7:0] cmd);
        return (cmd >= CMD_READ_INST) && (cmd <= CMD_READ_SPECIAL);
    endfunction

endpackage

// File: rtl/gpu_host_bridge_if.sv
// Shared RAM/register access bus between the bridge and the shader cores.
// master: bridge side (drives select, strobes, address, write data).
// slave : core-array side (returns muxed read data and its valid flag).
interface gpu_host_bridge_if #(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned CORE_COUNT    = 4
);
    logic [CORE_COUNT-1:0]    core_select;
    logic                     enable_write_inst_ram;
    logic                     enable_write_data_ram;
    logic                     enable_read_inst_ram;
    logic                     enable_read_data_ram;
    logic                     enable_read_register;
    logic                     enable_read_floatreg;
    logic                     enable_read_special;
    logic [ADDRESS_WIDTH-1:0] rw_address;
    logic [WORD_WIDTH-1:0]    write_data;
    logic [WORD_WIDTH-1:0]    read_data;
    logic                     read_valid;

    modport master (
        output core_select,
        output enable_write_inst_ram, enable_write_data_ram,
        output enable_read_inst_ram, enable_read_data_ram,
        output enable_read_register, enable_read_floatreg, enable_read_special,
        output rw_address, write_data,
        input  read_data, read_valid
    );

    modport slave (
        input  core_select,
        input  enable_write_inst_ram, enable_write_data_ram,
        input  enable_read_inst_ram, enable_read_data_ram,
        input  enable_read_register, enable_read_floatreg, enable_read_special,
        input  rw_address, write_data,
        output read_data, read_valid
    );
endinterface

// File: rtl/gpu_exception_select.sv
// Priority encoder returning the exception data of the lowest-index core
// whose exception flag is set, or zero when no core is excepting.
// Ports: core_exception_i (per-core flags), core_exception_data_i (24 bits
// per core, core i at [24i+23:24i]), exception_data_o (selected data).
module gpu_exception_select #(
    parameter int unsigned CORE_COUNT = 4
) (
    input  logic [CORE_COUNT-1:0]    core_exception_i,
    input  logic [24*CORE_COUNT-1:0] core_exception_data_i,
    output logic [23:0]              exception_data_o
);

    // Scan upward; the first hit wins
    always_comb begin
        logic found;
        found            = 1'b0;
        exception_data_o = '0;
        for (int i = 0; i < int'(CORE_COUNT); i++) begin
            if (!found && core_exception_i[i]) begin
                exception_data_o = core_exception_data_i[24*i +: 24];
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_host_bridge.sv
// HPS-to-GPU command bridge. Decodes the H2F PIO word into a request/busy
// handshake, issues accesses on the shared core bus, and reports status and
// command results on the F2H PIO word.
// Ports: clock/reset (sync, active-high); h2f_value in, f2h_value out;
// core_reset_n, core_run out; core_halted, core_exception,
// core_exception_data in; bus (master side of the core access bus).
module gpu_host_bridge
    import gpu_host_bridge_pkg::*;
#(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned CORE_COUNT    = 4,
    parameter int unsigned READ_TIMEOUT  = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               h2f_value,
    output logic [31:0]               f2h_value,
    output logic                      core_reset_n,
    output logic [CORE_COUNT-1:0]     core_run,
    input  logic [CORE_COUNT-1:0]     core_halted,
    input  logic [CORE_COUNT-1:0]     core_exception,
    input  logic [24*CORE_COUNT-1:0]  core_exception_data,
    gpu_host_bridge_if.master         bus
);

    localparam int unsigned TIMER_WIDTH = $clog2(READ_TIMEOUT + 1);

    // H2F field decode
    logic        host_rstn;
    logic        host_run;
    logic        host_req;
    logic [7:0]  h2f_cmd;
    logic [15:0] h2f_param;
    logic        unused_h2f;

    assign host_rstn  = h2f_value[H2F_RESET_N];
    assign host_run   = h2f_value[H2F_RUN];
    assign host_req   = h2f_value[H2F_REQUEST];
    assign h2f_cmd    = h2f_value[23:16];
    assign h2f_param  = h2f_value[15:0];
    assign unused_h2f = ^h2f_value[28:24];

    logic [2:0]               state_q, state_d;
    logic                     exited_q, exited_d;
    logic                     busy_q, busy_d;
    logic                     err_q, err_d;
    logic [23:0]              data_q, data_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [CORE_COUNT-1:0]    run_mask_q, run_mask_d;
    logic [CORE_COUNT-1:0]    sel_q, sel_d;
    logic                     bcast_q, bcast_d;
    logic [7:0]               cmd_q, cmd_d;
    logic [15:0]              param_q, param_d;
    strobe_t                  strobe_q, strobe_d;
    logic [ADDRESS_WIDTH-1:0] rw_addr_q, rw_addr_d;
    logic [TIMER_WIDTH-1:0]   timer_q, timer_d;
    logic [31:0]              write_reg_q, write_reg_d;
    logic [31:0]              read_reg_q, read_reg_d;
    logic [23:0]              exc_data;

    gpu_exception_select #(
        .CORE_COUNT (CORE_COUNT)
    ) u_exception_select (
        .core_exception_i      (core_exception),
        .core_exception_data_i (core_exception_data),
        .exception_data_o      (exc_data)
    );

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        exited_d    = exited_q;
        busy_d      = busy_q;
        err_d       = err_q;
        data_d      = data_q;
        addr_d      = addr_q;
        run_mask_d  = run_mask_q;
        sel_d       = sel_q;
        bcast_d     = bcast_q;
        cmd_d       = cmd_q;
        param_d     = param_q;
        strobe_d    = '0;
        rw_addr_d   = rw_addr_q;
        timer_d     = timer_q;
        write_reg_d = write_reg_q;
        read_reg_d  = read_reg_q;

        case (state_q)
            ST_INIT: begin
                exited_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end

            ST_IDLE: begin
                if (host_req && !host_run) begin
                    cmd_d   = h2f_cmd;
                    param_d = h2f_param;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_ISSUE;
                    // Strobes are registered here so they are high during ISSUE;
                    // a read toward a broadcast selection never reaches the bus.
                    if (!(is_read_cmd(h2f_cmd) && bcast_q)) begin
                        case (h2f_cmd)
                            CMD_WRITE_INST:    strobe_d.write_inst    = 1'b1;
                            CMD_WRITE_DATA:    strobe_d.write_data    = 1'b1;
                            CMD_READ_INST:     strobe_d.read_inst     = 1'b1;
                            CMD_READ_DATA:     strobe_d.read_data     = 1'b1;
                            CMD_READ_REGISTER: strobe_d.read_register = 1'b1;
                            CMD_READ_FLOATREG: strobe_d.read_floatreg = 1'b1;
                            CMD_READ_SPECIAL:  strobe_d.read_special  = 1'b1;
                            default: ;
                        endcase
                    end
                    case (h2f_cmd)
                        CMD_WRITE_INST, CMD_WRITE_DATA,
                        CMD_READ_INST, CMD_READ_DATA:
                            rw_addr_d = addr_q;
                        CMD_READ_REGISTER, CMD_READ_FLOATREG, CMD_READ_SPECIAL:
                            rw_addr_d = ADDRESS_WIDTH'(h2f_param[4:0]);
                        default: ;
                    endcase
                end
            end

            ST_ISSUE: begin
                state_d = ST_DONE;
                timer_d = '0;
                case (cmd_q)
                    CMD_PUT_LOW16:   write_reg_d[15:0]  = param_q;
                    CMD_PUT_HIGH16:  write_reg_d[31:16] = param_q;
                    CMD_SET_ADDRESS: addr_d = param_q[ADDRESS_WIDTH-1:0];
                    CMD_SET_CORE: begin
                        if (param_q[4]) begin
                            bcast_d = 1'b1;
                            sel_d   = '1;
                        end else if (32'(param_q[3:0]) < CORE_COUNT) begin
                            bcast_d = 1'b0;
                            sel_d   = CORE_COUNT'(1) << param_q[3:0];
                        end else begin
                            err_d  = 1'b1;
                            data_d = ERR_DEAD00;
                        end
                    end
                    CMD_WRITE_INST, CMD_WRITE_DATA:
                        addr_d = addr_q + ADDRESS_WIDTH'(1);
                    CMD_READ_INST, CMD_READ_DATA, CMD_READ_REGISTER,
                    CMD_READ_FLOATREG, CMD_READ_SPECIAL: begin
                        if (bcast_q) begin
                            err_d  = 1'b1;
                            data_d = ERR_DEAD00;
                        end else begin
                            if (cmd_q == CMD_READ_INST || cmd_q == CMD_READ_DATA) begin
                                addr_d = addr_q + ADDRESS_WIDTH'(1);
                            end
                            // Data may come back in the strobe cycle itself
                            if (bus.read_valid) begin
                                read_reg_d = 32'(bus.read_data);
                            end else begin
                                state_d = ST_WAIT_READ;
                            end
                        end
                    end
                    CMD_GET_LOW16:     data_d = {8'h00, read_reg_q[15:0]};
                    CMD_GET_HIGH16:    data_d = {8'h00, read_reg_q[31:16]};
                    CMD_SET_RUN_MASK:  run_mask_d = param_q[CORE_COUNT-1:0];
                    CMD_GET_EXCEPTION: data_d = exc_data;
                    default: begin
                        err_d  = 1'b1;
                        data_d = ERR_DEAD00;
                    end
                endcase
            end

            ST_WAIT_READ: begin
                if (bus.read_valid) begin
                    read_reg_d = 32'(bus.read_data);
                    state_d    = ST_DONE;
                end else if (timer_q == TIMER_WIDTH'(READ_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    data_d  = ERR_DEAD01;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q + TIMER_WIDTH'(1);
                end
            end

            ST_DONE: begin
                // No re-trigger: request must drop before the next command
                if (!host_req) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    // Bridge state; the host soft reset clears it like the hard reset
    always_ff @(posedge clock) begin
        if (reset || !host_rstn) begin
            state_q    <= ST_INIT;
            exited_q   <= 1'b0;
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            data_q     <= '0;
            addr_q     <= '0;
            run_mask_q <= '1;
            sel_q      <= CORE_COUNT'(1);
            bcast_q    <= 1'b0;
            cmd_q      <= '0;
            param_q    <= '0;
            strobe_q   <= '0;
            rw_addr_q  <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            exited_q   <= exited_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            data_q     <= data_d;
            addr_q     <= addr_d;
            run_mask_q <= run_mask_d;
            sel_q      <= sel_d;
            bcast_q    <= bcast_d;
            cmd_q      <= cmd_d;
            param_q    <= param_d;
            strobe_q   <= strobe_d;
            rw_addr_q  <= rw_addr_d;
            timer_q    <= timer_d;
        end
    end

    // Data registers survive a host soft reset
    always_ff @(posedge clock) begin
        if (reset) begin
            write_reg_q <= '0;
            read_reg_q  <= '0;
        end else if (host_rstn) begin
            write_reg_q <= write_reg_d;
            read_reg_q  <= read_reg_d;
        end
    end

    // Status word
    always_comb begin
        f2h_value                    = '0;
        f2h_value[F2H_EXITED_RESET]  = exited_q;
        f2h_value[F2H_BUSY]          = busy_q;
        f2h_value[F2H_CMD_ERROR]     = err_q;
        f2h_value[F2H_ANY_HALTED]    = |core_halted;
        f2h_value[F2H_ANY_EXCEPTION] = |core_exception;
        f2h_value[DATA_FIELD_WIDTH-1:0] = data_q;
    end

    assign core_reset_n = !reset && host_rstn;
    assign core_run     = run_mask_q & {CORE_COUNT{host_run}};

    assign bus.core_select           = sel_q;
    assign bus.enable_write_inst_ram = strobe_q.write_inst;
    assign bus.enable_write_data_ram = strobe_q.write_data;
    assign bus.enable_read_inst_ram  = strobe_q.read_inst;
    assign bus.enable_read_data_ram  = strobe_q.read_data;
    assign bus.enable_read_register  = strobe_q.read_register;
    assign bus.enable_read_floatreg  = strobe_q.read_floatreg;
    assign bus.enable_read_special   = strobe_q.read_special;
    assign bus.rw_address            = rw_addr_q;
    assign bus.write_data            = WORD_WIDTH'(write_reg_q);

endmodule

// File: tb/tb_gpu_host_bridge.sv
// Directed bench for gpu_host_bridge: host command sequences with
// hand-computed F2H words, bus strobe/address observation and a simple
// delayed read responder.
module tb_gpu_host_bridge;
    import gpu_host_bridge_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] h2f_value;
    logic [31:0] f2h_value;
    logic        core_reset_n;
    logic [3:0]  core_run;
    logic [3:0]  core_halted;
    logic [3:0]  core_exception;
    logic [95:0] core_exception_data;

    logic        host_rstn;
    logic        host_run;
    logic        host_req;
    logic [7:0]  host_cmd;
    logic [15:0] host_param;

    assign h2f_value = {host_rstn, host_run, host_req, 5'b0, host_cmd, host_param};

    gpu_host_bridge_if #(.WORD_WIDTH(32), .ADDRESS_WIDTH(16), .CORE_COUNT(4)) bus ();

    gpu_host_bridge #(
        .WORD_WIDTH    (32),
        .ADDRESS_WIDTH (16),
        .CORE_COUNT    (4),
        .READ_TIMEOUT  (15)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .h2f_value           (h2f_value),
        .f2h_value           (f2h_value),
        .core_reset_n        (core_reset_n),
        .core_run            (core_run),
        .core_halted         (core_halted),
        .core_exception      (core_exception),
        .core_exception_data (core_exception_data),
        .bus                 (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus observer and read responder (rd_delay < 0 means never answer)
    int          wr_inst_n = 0;
    int          wr_data_n = 0;
    int          rd_n      = 0;
    logic [15:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    int          rd_delay  = 0;
    int          rd_cnt    = -1;
    logic [31:0] rd_value  = '0;
    logic [6:0]  stb;

    assign stb = {bus.enable_write_inst_ram, bus.enable_write_data_ram,
                  bus.enable_read_inst_ram, bus.enable_read_data_ram,
                  bus.enable_read_register, bus.enable_read_floatreg,
                  bus.enable_read_special};

    always @(negedge clock) begin
        bus.read_valid = 1'b0;
        if (bus.enable_write_inst_ram) begin
            wr_inst_n++;
            last_addr  = bus.rw_address;
            last_wdata = bus.write_data;
        end
        if (bus.enable_write_data_ram) begin
            wr_data_n++;
            last_addr  = bus.rw_address;
            last_wdata = bus.write_data;
        end
        if (|stb[4:0]) begin
            rd_n++;
            last_addr = bus.rw_address;
            if (rd_delay >= 0) rd_cnt = rd_delay;
        end
        if (rd_cnt == 0) begin
            bus.read_valid = 1'b1;
            bus.read_data  = rd_value;
        end
        if (rd_cnt >= 0) rd_cnt--;
    end

    // Issue one command, hold request, then drop it and wait for busy to clear
    task automatic do_cmd(input logic [7:0] c, input logic [15:0] p);
        @(negedge clock);
        host_cmd   = c;
        host_param = p;
        host_req   = 1'b1;
        repeat (20) @(negedge clock);
        host_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (!f2h_value[30]) break;
        end
        check($sformatf("busy_clear_cmd%0d", c), 32'(f2h_value[30]), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset               = 1'b1;
        host_rstn           = 1'b1;
        host_run            = 1'b0;
        host_req            = 1'b0;
        host_cmd            = '0;
        host_param          = '0;
        core_halted         = '0;
        core_exception      = '0;
        core_exception_data = '0;

        repeat (3) @(negedge clock);
        check("rst_f2h", f2h_value, 32'h4000_0000);
        check("rst_core_select", 32'(bus.core_select), 32'h1);
        check("rst_rw_address", 32'(bus.rw_address), 32'h0);
        check("rst_strobes", 32'(stb), 32'h0);
        check("rst_core_reset_n", 32'(core_reset_n), 32'h0);

        reset = 1'b0;
        @(negedge clock);
        check("exit_reset_f2h", f2h_value, 32'h8000_0000);
        check("exit_core_run", 32'(core_run), 32'h0);
        check("exit_core_reset_n", 32'(core_reset_n), 32'h1);

        // Write path with address wrap
        do_cmd(CMD_SET_CORE, 16'h0002);
        check("sel_core2", 32'(bus.core_select), 32'h4);
        do_cmd(CMD_SET_ADDRESS, 16'hFFFF);
        do_cmd(CMD_PUT_LOW16, 16'hBEEF);
        do_cmd(CMD_PUT_HIGH16, 16'hDEAD);

        @(negedge clock);
        host_cmd = CMD_WRITE_DATA;
        host_param = 16'h0;
        host_req = 1'b1;
        @(negedge clock);
        check("wr_busy_n1", 32'(f2h_value[30]), 32'h1);
        check("wr_strobe_n1", 32'(stb), 32'b0100000);
        check("wr_addr_n1", 32'(bus.rw_address), 32'h0000_FFFF);
        check("wr_data_n1", bus.write_data, 32'hDEAD_BEEF);
        host_req = 1'b0;
        @(negedge clock);
        check("wr_strobe_n2", 32'(stb), 32'h0);
        check("wr_busy_n2", 32'(f2h_value[30]), 32'h1);
        @(negedge clock);
        check("wr_busy_n3", 32'(f2h_value[30]), 32'h0);

        do_cmd(CMD_WRITE_DATA, 16'h0);
        check("wr2_addr_wrap", 32'(last_addr), 32'h0);
        check("wr2_count", wr_data_n, 2);
        check("wr2_data", last_wdata, 32'hDEAD_BEEF);

        // Delayed read
        rd_delay = 3;
        rd_value = 32'h1234_5678;
        do_cmd(CMD_READ_INST, 16'h0);
        check("rd_inst_addr", 32'(last_addr), 32'h1);
        check("rd_inst_count", rd_n, 1);
        do_cmd(CMD_GET_LOW16, 16'h0);
        check("get_low16", f2h_value, 32'h8000_5678);
        do_cmd(CMD_GET_HIGH16, 16'h0);
        check("get_high16", f2h_value, 32'h8000_1234);

        // Read timeout
        rd_delay = -1;
        do_cmd(CMD_READ_DATA, 16'h0);
        check("timeout_f2h", f2h_value, 32'hA0DE_AD01);
        check("timeout_rd_count", rd_n, 2);
        do_cmd(CMD_GET_LOW16, 16'h0);
        check("err_cleared_readreg_kept", f2h_value, 32'h8000_5678);

        // Broadcast restrictions and invalid selects
        do_cmd(CMD_SET_CORE, 16'h0010);
        check("bcast_select", 32'(bus.core_select), 32'hF);
        do_cmd(CMD_READ_REGISTER, 16'h0005);
        check("bcast_read_err", f2h_value, 32'hA0DE_AD00);
        check("bcast_read_no_strobe", rd_n, 2);
        do_cmd(CMD_SET_CORE, 16'h0000);
        check("sel_core0_f2h", f2h_value, 32'h80DE_AD00);
        check("sel_core0", 32'(bus.core_select), 32'h1);
        do_cmd(CMD_SET_CORE, 16'h0009);
        check("bad_core_err", f2h_value, 32'hA0DE_AD00);
        check("bad_core_keeps_sel", 32'(bus.core_select), 32'h1);
        do_cmd(CMD_GET_LOW16, 16'h0);
        do_cmd(8'd15, 16'h0);
        check("unknown_cmd_err", f2h_value, 32'hA0DE_AD00);

        // Register read answered in the strobe cycle
        rd_delay = 0;
        rd_value = 32'hCAFE_0042;
        do_cmd(CMD_READ_REGISTER, 16'h001F);
        check("readx_addr", 32'(last_addr), 32'h1F);
        check("readx_count", rd_n, 3);
        do_cmd(CMD_GET_LOW16, 16'h0);
        check("readx_low16", f2h_value, 32'h8000_0042);

        // Run control and exception reporting
        do_cmd(CMD_SET_RUN_MASK, 16'h0005);
        @(negedge clock);
        host_run = 1'b1;
        @(negedge clock);
        check("run_mask_core_run", 32'(core_run), 32'h5);
        host_cmd = CMD_GET_HIGH16;
        host_req = 1'b1;
        repeat (3) @(negedge clock);
        check("req_during_run_ignored", f2h_value, 32'h8000_0042);
        host_req = 1'b0;
        core_halted         = 4'b0100;
        core_exception      = 4'b1010;
        core_exception_data = {24'h111111, 24'h000000, 24'hABCDEF, 24'h000000};
        @(negedge clock);
        check("status_bits", f2h_value, 32'h9800_0042);
        host_run = 1'b0;
        do_cmd(CMD_GET_EXCEPTION, 16'h0);
        check("get_exception", f2h_value, 32'h98AB_CDEF);

        // Host soft reset keeps data registers
        host_rstn = 1'b0;
        repeat (2) @(negedge clock);
        check("soft_rst_f2h", f2h_value, 32'h5800_0000);
        check("soft_rst_core_reset_n", 32'(core_reset_n), 32'h0);
        host_rstn = 1'b1;
        @(negedge clock);
        check("soft_exit_f2h", f2h_value, 32'h9800_0000);
        host_run = 1'b1;
        @(negedge clock);
        check("soft_run_mask_ones", 32'(core_run), 32'hF);
        host_run = 1'b0;
        do_cmd(CMD_GET_HIGH16, 16'h0);
        check("soft_read_reg_kept", f2h_value, 32'h9800_CAFE);
        do_cmd(CMD_WRITE_INST, 16'h0);
        check("soft_write_reg_kept", last_wdata, 32'hDEAD_BEEF);
        check("soft_addr_cleared", 32'(last_addr), 32'h0);
        check("wr_inst_count", wr_inst_n, 1);

        // Hard reset during a pending read
        core_halted    = '0;
        core_exception = '0;
        rd_delay       = -1;
        @(negedge clock);
        host_cmd = CMD_READ_DATA;
        host_req = 1'b1;
        @(negedge clock);
        check("midrd_strobe", 32'(bus.enable_read_data_ram), 32'h1);
        reset    = 1'b1;
        host_req = 1'b0;
        @(negedge clock);
        check("midrd_strobe_dropped", 32'(stb), 32'h0);
        check("midrd_f2h", f2h_value, 32'h4000_0000);
        reset = 1'b0;
        @(negedge clock);
        check("midrd_exit_f2h", f2h_value, 32'h8000_0000);
        do_cmd(CMD_GET_LOW16, 16'h0);
        check("hard_rst_read_reg", f2h_value, 32'h8000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
